inst_rom_resp: RTL
==================

INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DEPTH_LOG2, 10, log2 of instruction word count.
- NOP_INST, 32'h00000000, word returned on fetch error.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ce  input  1  fetch request / chip enable from PC stage.
- addr  input  32  byte address of instruction to fetch.
- inst  output  32  fetched instruction (registered).
- inst_valid  output  1  inst holds a response to the previous-cycle fetch.
- addr_err  output  1  previous fetch was misaligned or out of range.
- ready  output  1  a fetch presented this cycle will be accepted.
- load_en  input  1  program-load mode request.
- load_we  input  1  load write strobe.
- load_addr  input  DEPTH_LOG2  word index to write.
- load_data  input  32  instruction word to write.
- load_cnt  output  DEPTH_LOG2+1  words written in current load session.
REQ-003 The reset is one clock domain, asynchronous assertion, active-low; no other clock SHALL exist.

Function
REQ-004 Storage SHALL be 2^DEPTH_LOG2 words x 32 bits, not cleared by reset.
REQ-005 FSM states SHALL be SERVE and LOAD; SERVE --load_en=1--> LOAD; LOAD --load_en=0--> SERVE; otherwise hold.
REQ-006 ready SHALL be combinational: 1 iff state==SERVE and load_en==0.
REQ-007 Accepted fetch (ce=1, ready=1): 1-cycle latency; next edge inst<=word, inst_valid<=1.
REQ-008 Word index SHALL be addr[DEPTH_LOG2+1:2].
REQ-009 Error case: addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0 -> inst<=NOP_INST, inst_valid<=1, addr_err<=1; else addr_err<=0.
REQ-010 ce=1, ready=0 (stall): inst holds, inst_valid<=0, addr_err<=0.
REQ-011 ce=0: inst<=32'h0, inst_valid<=0, addr_err<=0.
REQ-012 Back-to-back fetches on consecutive cycles SHALL each produce one response, no bubbles.
REQ-013 Writes: only in LOAD with load_we=1 -> mem[load_addr]<=load_data at the edge; load_we in SERVE ignored.
REQ-014 load_cnt SHALL clear to 0 on the SERVE->LOAD transition, +1 per accepted write, saturate at 2^DEPTH_LOG2, hold in SERVE.
REQ-015 Fetch and write never overlap (ready=0 throughout LOAD and on the cycle load_en rises); no read-during-write behaviour needed.
REQ-016 Word written in LOAD SHALL be readable by the first fetch after return to SERVE.

Reset
REQ-017 rst=0 SHALL immediately force: state=SERVE, inst=0, inst_valid=0, addr_err=0, load_cnt=0.
REQ-018 Reset mid-LOAD SHALL abort the session; words already written SHALL be retained.
REQ-019 First fetch accepted on the first rising edge after rst deasserts.

Verification
REQ-020 Load words 0..3 = 32'h11111111..44444444, drop load_en, fetch addr 0,4,8,12 back-to-back -> inst 11111111..44444444 on cycles 1..4, inst_valid=1 each, load_cnt=4.
REQ-021 Fetch addr 32'h00000006 -> inst=NOP_INST, addr_err=1, inst_valid=1; fetch addr 32'h00001000 (DEPTH_LOG2=10) -> same.
REQ-022 ce=1 with load_en=1 -> ready=0, inst_valid=0, inst unchanged; load_we in SERVE with load_en=0 -> memory unchanged.
REQ-023 1025 writes in one session -> load_cnt saturates at 1024.
REQ-024 rst low mid-LOAD after 2 writes, release, fetch those 2 words -> written data returned, load_cnt=0, state SERVE.
REQ-025 ce=0 after a valid fetch -> next cycle inst=0, inst_valid=0.

Source files
------------

// File: rtl/inst_rom_resp.sv
// Instruction ROM with a program-load port: registered fetch responses in SERVE, word writes in LOAD.
// Latency: one cycle from an accepted fetch (ce & ready) to inst/inst_valid/addr_err.
// Backpressure: ready drops during LOAD and on the cycle load_en rises; a stalled fetch holds inst.
//
// Ports:
//   clk, rst          single clock, asynchronous active-low reset
//   ce, addr          fetch request and byte address from the PC stage
//   inst, inst_valid  registered fetched word and its response strobe
//   addr_err          the fetch was misaligned or outside the array (inst = NOP_INST)
//   ready             a fetch presented this cycle will be accepted
//   load_en           program-load mode request
//   load_we           write strobe, honoured only while in LOAD
//   load_addr/data    word index and data for a load write
//   load_cnt          words written in the current load session (saturating)
module inst_rom_resp #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_INST   = 32'h00000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [31:0]           addr,
   output logic [31:0]           inst,
   output logic                  inst_valid,
   output logic                  addr_err,
   output logic                  ready,
   input  logic                  load_en,
   input  logic                  load_we,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data,
   output logic [DEPTH_LOG2:0]   load_cnt
);

   localparam int                DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {
      SERVE = 1'b0,
      LOAD  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   // Storage is deliberately not reset so a loaded program survives a reset.
   logic [31:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  wr_en;
   logic                  enter_load;

   always_comb begin
      state_nxt = state;
      case (state)
         SERVE:   if (load_en)  state_nxt = LOAD;
         LOAD:    if (!load_en) state_nxt = SERVE;
         default: state_nxt = SERVE;
      endcase
   end

   // load_en is looked at directly so the fetch path is closed on the same
   // cycle the load request appears; this keeps fetch and write disjoint.
   assign ready        = (state == SERVE) && !load_en;
   assign misaligned   = |addr[1:0];
   assign out_of_range = |addr[31:DEPTH_LOG2+2];
   assign rd_idx       = addr[DEPTH_LOG2+1:2];
   assign wr_en        = (state == LOAD) && load_we;
   assign enter_load   = (state == SERVE) && (state_nxt == LOAD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SERVE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst       <= 32'h0;
         inst_valid <= 1'b0;
         addr_err   <= 1'b0;
      end else if (ce) begin
         if (ready) begin
            inst_valid <= 1'b1;
            if (misaligned || out_of_range) begin
               inst     <= NOP_INST;
               addr_err <= 1'b1;
            end else begin
               inst     <= mem[rd_idx];
               addr_err <= 1'b0;
            end
         end else begin
            // Stalled fetch: keep the last word visible, but flag no response.
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
         end
      end else begin
         inst       <= 32'h0;
         inst_valid <= 1'b0;
         addr_err   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_cnt <= '0;
      end else if (enter_load) begin
         load_cnt <= '0;
      end else if (wr_en && (load_cnt != CNT_MAX)) begin
         load_cnt <= load_cnt + 1'b1;
      end
   end

endmodule
